// File: rtl/coherence_bus_arbiter_if.sv
// Bus bundle between coherence_bus_arbiter and the two cache controllers plus memory.
// master = arbiter side, slave = caches/memory side.
interface coherence_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 8
);
   logic [1:0]        req;
   logic [1:0]        op0;
   logic [1:0]        op1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [1:0]        grant;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        snp_valid;
   logic [1:0]        snp_op;
   logic [ADDR_W-1:0] snp_addr;
   logic [1:0]        snp_ack;
   logic [1:0]        snp_wb;
   logic [DATA_W-1:0] snp_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              abort_mem;
   logic              busy;
   logic              timeout_err;

   modport master (
      input  req, op0, op1, addr0, addr1, snp_ack, snp_wb, snp_wdata, mem_rdata,
      output grant, done, rdata, snp_valid, snp_op, snp_addr, mem_addr, mem_we, mem_wdata,
             abort_mem, busy, timeout_err
   );

   modport slave (
      output req, op0, op1, addr0, addr1, snp_ack, snp_wb, snp_wdata, mem_rdata,
      input  grant, done, rdata, snp_valid, snp_op, snp_addr, mem_addr, mem_we, mem_wdata,
             abort_mem, busy, timeout_err
   );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Two-cache MSI snooping-bus arbiter: grants the bus, broadcasts the snoop, handles write-back.
// Optional snoop-ack timeout is enabled by defining COH_ARB_SNOOP_TIMEOUT_EN.
module coherence_bus_arbiter #(
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input logic                     clock,
   input logic                     reset,
   coherence_bus_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      StIdle,
      StSnoop,
      StWb,
      StMemRd,
      StMemWait,
      StDone
   } state_e;

   localparam logic [1:0] OpInv = 2'b11;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              timeout_err_q, timeout_err_d;

   logic       valid0, valid1;
   logic       other;
   logic       ack, ack_wb;
   logic       snoop_go;
   logic       timed_out;
   logic [1:0] owner_oh;
   logic [1:0] other_oh;

   assign valid0   = bus.req[0] & (bus.op0 != 2'b00);
   assign valid1   = bus.req[1] & (bus.op1 != 2'b00);
   assign other    = ~owner_q;
   assign owner_oh = owner_q ? 2'b10 : 2'b01;
   assign other_oh = owner_q ? 2'b01 : 2'b10;
   // Only the non-owner's response counts; an ack from the owner is ignored.
   assign ack      = bus.snp_ack[other];
   assign ack_wb   = bus.snp_wb[other];

`ifdef COH_ARB_SNOOP_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            expired;

   assign expired   = (state_q == StSnoop) && (cnt_q == CntW'(TIMEOUT - 1));
   assign timed_out = expired & ~ack;
   assign snoop_go  = ack | expired;

   always_comb begin
      cnt_d = '0;
      if (state_q == StSnoop) cnt_d = cnt_q + CntW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT);
   assign timed_out      = 1'b0;
   assign snoop_go       = ack;
`endif

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_owner_d  = last_owner_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         StIdle: begin
            if (valid0 | valid1) begin
               owner_d = (valid0 & valid1) ? ~last_owner_q : valid1;
               op_d    = owner_d ? bus.op1 : bus.op0;
               addr_d  = owner_d ? bus.addr1 : bus.addr0;
               state_d = StSnoop;
            end
         end
         StSnoop: begin
            if (snoop_go) begin
               timeout_err_d = timeout_err_q | timed_out;
               if (ack && ack_wb) begin
                  wdata_d = bus.snp_wdata;
                  state_d = StWb;
               end else if (op_q == OpInv) begin
                  state_d = StDone;
               end else begin
                  state_d = StMemRd;
               end
            end
         end
         StWb: begin
            rdata_d = wdata_q;
            state_d = StDone;
         end
         StMemRd:   state_d = StMemWait;
         StMemWait: begin
            rdata_d = bus.mem_rdata;
            state_d = StDone;
         end
         StDone: begin
            last_owner_d = owner_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.grant       = 2'b00;
      bus.done        = 2'b00;
      bus.snp_valid   = 2'b00;
      bus.mem_addr    = '0;
      bus.mem_we      = 1'b0;
      bus.abort_mem   = 1'b0;
      bus.busy        = (state_q != StIdle);
      bus.rdata       = rdata_q;
      bus.snp_op      = op_q;
      bus.snp_addr    = addr_q;
      bus.mem_wdata   = wdata_q;
      bus.timeout_err = timeout_err_q;
      if (state_q != StIdle) bus.grant = owner_oh;
      case (state_q)
         StSnoop: bus.snp_valid = other_oh;
         StWb: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_q;
            bus.abort_mem = 1'b1;
         end
         StMemRd: bus.mem_addr = addr_q;
         StDone:  bus.done     = owner_oh;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         owner_q       <= 1'b0;
         last_owner_q  <= 1'b1;
         op_q          <= 2'b00;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_owner_q  <= last_owner_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Self-checking bench for coherence_bus_arbiter: table of transactions, scoreboard queue,
// cache snoop responder and a registered ROM as memory.
module tb_coherence_bus_arbiter;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;

   typedef struct {
      logic [1:0]    req;
      logic [1:0]    op0;
      logic [1:0]    op1;
      logic [AW-1:0] addr0;
      logic [AW-1:0] addr1;
      int            delay;
      logic          wb;
      logic [DW-1:0] wdata;
      logic          spur;
      logic          two;
      logic          first;
      int            lat_a;
      logic [DW-1:0] rd_a;
      logic          chk_a;
      int            lat_b;
      logic [DW-1:0] rd_b;
      logic          chk_b;
   } vec_t;

   typedef struct {
      logic          owner;
      logic [1:0]    op;
      logic [AW-1:0] addr;
      int            at;
      logic [DW-1:0] rdata;
      logic          chk;
      logic          wb;
      logic [DW-1:0] wdata;
   } exp_t;

   logic clock;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   int            cur_delay;
   logic          cur_wb;
   logic          cur_spur;
   int            scnt;

   coherence_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   coherence_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory: word at address a holds 0xA0 | a, returned one cycle after the address.
   always @(posedge clock) bus.mem_rdata <= 8'hA0 | 8'(bus.mem_addr);

   function automatic logic [1:0] oh(input logic b);
      return b ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      exp_t e;
      @(negedge clock);
      if (q.size() == 0) begin
         chk("idle busy", 32'(bus.busy), 0);
         chk("idle grant", 32'(bus.grant), 0);
         chk("idle done", 32'(bus.done), 0);
         chk("idle mem_we", 32'(bus.mem_we), 0);
         chk("idle snp_valid", 32'(bus.snp_valid), 0);
      end else begin
         e = q[0];
         if (bus.busy) chk("grant", 32'(bus.grant), 32'(oh(e.owner)));
         else          chk("grant between", 32'(bus.grant), 0);
         if (bus.snp_valid != 2'b00) begin
            chk("snp_valid", 32'(bus.snp_valid), 32'(oh(!e.owner)));
            chk("snp_op", 32'(bus.snp_op), 32'(e.op));
            chk("snp_addr", 32'(bus.snp_addr), 32'(e.addr));
         end
         if (bus.mem_we) begin
            chk("mem_we allowed", 32'(bus.mem_we), 32'(e.wb));
            chk("wb mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("wb mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            chk("wb abort_mem", 32'(bus.abort_mem), 1);
         end else begin
            chk("abort_mem", 32'(bus.abort_mem), 0);
            if (bus.mem_addr != '0) begin
               chk("read mem_addr", 32'(bus.mem_addr), 32'(e.addr));
               checks++;
               if (e.op == 2'b11 || e.wb) begin
                  errors++;
                  $display("FAIL mem read: got read of %0h expected none (cycle %0d)",
                           bus.mem_addr, cyc);
               end
            end
         end
         if (bus.done != 2'b00) begin
            chk("done", 32'(bus.done), 32'(oh(e.owner)));
            chk("done cycle", 32'(cyc), 32'(e.at));
            if (e.chk) chk("rdata", 32'(bus.rdata), 32'(e.rdata));
            bus.req[e.owner] = 1'b0;
            void'(q.pop_front());
         end
      end
`ifndef COH_ARB_SNOOP_TIMEOUT_EN
      chk("timeout_err", 32'(bus.timeout_err), 0);
`endif
      // Snooping cache: acks after cur_delay SNOOP cycles; optionally the owner acks early.
      if (bus.snp_valid != 2'b00) begin
         if (scnt >= cur_delay) begin
            bus.snp_ack = bus.snp_valid;
            bus.snp_wb  = cur_wb ? bus.snp_valid : 2'b00;
         end else begin
            bus.snp_ack = cur_spur ? bus.grant : 2'b00;
            bus.snp_wb  = cur_spur ? bus.grant : 2'b00;
         end
         scnt++;
      end else begin
         scnt        = 0;
         bus.snp_ack = 2'b00;
         bus.snp_wb  = 2'b00;
      end
   endtask

   task automatic run_row(input vec_t v);
      exp_t e;
      cur_delay     = v.delay;
      cur_wb        = v.wb;
      cur_spur      = v.spur;
      bus.snp_wdata = v.wdata;
      e.owner = v.first;
      e.op    = v.first ? v.op1 : v.op0;
      e.addr  = v.first ? v.addr1 : v.addr0;
      e.at    = cyc + v.lat_a;
      e.rdata = v.rd_a;
      e.chk   = v.chk_a;
      e.wb    = v.wb;
      e.wdata = v.wdata;
      q.push_back(e);
      if (v.two) begin
         e.owner = !v.first;
         e.op    = v.first ? v.op0 : v.op1;
         e.addr  = v.first ? v.addr0 : v.addr1;
         e.at    = cyc + v.lat_b;
         e.rdata = v.rd_b;
         e.chk   = v.chk_b;
         q.push_back(e);
      end
      bus.op0   = v.op0;
      bus.op1   = v.op1;
      bus.addr0 = v.addr0;
      bus.addr1 = v.addr1;
      bus.req   = v.req;
      for (int i = 0; i < 60 && q.size() != 0; i++) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL completion: got %0d pending transactions expected 0", q.size());
         q.delete();
      end
      bus.req = 2'b00;
      step();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{2'b11, 2'b11, 2'b11, 3'd2, 3'd6, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,
                  2, 8'h00, 1'b0, 5, 8'h00, 1'b0};
      vecs[1] = '{2'b01, 2'b01, 2'b00, 3'd5, 3'd0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  4, 8'hA5, 1'b1, 0, 8'h00, 1'b0};
      vecs[2] = '{2'b10, 2'b00, 2'b10, 3'd0, 3'd3, 0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1,
                  3, 8'h3C, 1'b1, 0, 8'h00, 1'b0};
      vecs[3] = '{2'b01, 2'b11, 2'b00, 3'd4, 3'd0, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,
                  5, 8'h00, 1'b0, 0, 8'h00, 1'b0};
      vecs[4] = '{2'b11, 2'b01, 2'b10, 3'd1, 3'd7, 1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,
                  5, 8'hA7, 1'b1, 11, 8'hA1, 1'b1};
      vecs[5] = '{2'b01, 2'b01, 2'b00, 3'd2, 3'd0, 2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0,
                  5, 8'h5A, 1'b1, 0, 8'h00, 1'b0};
      vecs[6] = '{2'b10, 2'b00, 2'b11, 3'd0, 3'd6, 0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1,
                  3, 8'h00, 1'b0, 0, 8'h00, 1'b0};
      vecs[7] = '{2'b11, 2'b00, 2'b01, 3'd0, 3'd3, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                  4, 8'hA3, 1'b1, 0, 8'h00, 1'b0};

      reset         = 1'b1;
      bus.req       = 2'b00;
      bus.op0       = 2'b00;
      bus.op1       = 2'b00;
      bus.addr0     = '0;
      bus.addr1     = '0;
      bus.snp_ack   = 2'b00;
      bus.snp_wb    = 2'b00;
      bus.snp_wdata = '0;
      cur_delay     = 0;
      cur_wb        = 1'b0;
      cur_spur      = 1'b0;
      scnt          = 0;
      repeat (2) @(negedge clock);
      chk("reset grant", 32'(bus.grant), 0);
      chk("reset done", 32'(bus.done), 0);
      chk("reset snp_valid", 32'(bus.snp_valid), 0);
      chk("reset mem_we", 32'(bus.mem_we), 0);
      chk("reset abort_mem", 32'(bus.abort_mem), 0);
      chk("reset busy", 32'(bus.busy), 0);
      chk("reset rdata", 32'(bus.rdata), 0);
      chk("reset mem_addr", 32'(bus.mem_addr), 0);
      chk("reset timeout_err", 32'(bus.timeout_err), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) run_row(vecs[i]);

      // Reset while waiting for memory data: no completion, no write, then normal service.
      begin
         exp_t e;
         cur_delay = 0;
         cur_wb    = 1'b0;
         cur_spur  = 1'b0;
         e = '{1'b0, 2'b01, 3'd6, cyc + 4, 8'hA6, 1'b1, 1'b0, 8'h00};
         q.push_back(e);
         bus.op0   = 2'b01;
         bus.addr0 = 3'd6;
         bus.req   = 2'b01;
         repeat (3) step();
         chk("pre-reset busy", 32'(bus.busy), 1);
         reset   = 1'b1;
         bus.req = 2'b00;
         q.delete();
         step();
         chk("post-reset rdata", 32'(bus.rdata), 0);
         reset = 1'b0;
         step();
         run_row(vecs[1]);
      end

`ifdef COH_ARB_SNOOP_TIMEOUT_EN
      begin
         vec_t t;
         t = '{2'b01, 2'b01, 2'b00, 3'd2, 3'd0, 1000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
               18, 8'hA2, 1'b1, 0, 8'h00, 1'b0};
         chk("timeout_err before", 32'(bus.timeout_err), 0);
         run_row(t);
         chk("timeout_err sticky", 32'(bus.timeout_err), 1);
         run_row(vecs[1]);
         chk("timeout_err held", 32'(bus.timeout_err), 1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
